// File: rtl/button_encoder.sv
// button_encoder: debounced 16-button priority encoder with valid/ready output and sticky overflow
module button_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] buttons,
  input  logic        ready,
  input  logic        ovf_clr,
  output logic [3:0]  buttonNum,
  output logic        valid,
  output logic        multi,
  output logic        overflow,
  output logic        held
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {IDLE, PRESSED} state_t;
  logic [15:0]   r_sync [SYNC_STAGES];
  logic [15:0]   r_prev;
  logic [15:0]   r_stable;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  state_t        w_next;
  logic [15:0]   w_sync_v;
  logic          w_changed;
  logic          w_event;
  logic          w_hs;
  logic          w_drop;
  logic [3:0]    w_idx;
  logic          w_multi;
  assign w_sync_v  = r_sync[SYNC_STAGES-1];
  assign w_changed = w_sync_v != r_prev;
  assign w_hs      = valid && ready;
  assign w_drop    = w_event && valid && !w_hs;
  assign w_multi   = |(r_stable & (r_stable - 16'd1));
  // bring the raw asynchronous levels into the clock domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= buttons;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end
  // debounce: stable vector only follows a synchronized value that held long enough
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_prev <= w_sync_v;
      r_cnt  <= w_changed ? '0 : (r_cnt == CMAX ? r_cnt : r_cnt + CW'(1));
      if (!w_changed && r_cnt == CMAX) r_stable <= w_sync_v;
    end
  end
  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end
  // FSM next state: leave IDLE on any stable press, return only on full release
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && r_stable != '0) w_next = PRESSED;
    else if (r_state == PRESSED && r_stable == '0) w_next = IDLE;
  end
  // FSM output: a press event fires exactly on the IDLE->PRESSED transition
  always_comb begin
    w_event = (r_state == IDLE) && (r_stable != '0);
  end
  // lowest set index wins
  always_comb begin
    w_idx = '0;
    for (int i = 15; i >= 0; i--) if (r_stable[i]) w_idx = 4'(i);
  end
  // output register: load on accepted events, clear on handshake, flag dropped events
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buttonNum <= '0;
      valid     <= 1'b0;
      multi     <= 1'b0;
      overflow  <= 1'b0;
      held      <= 1'b0;
    end else begin
      held     <= r_stable != '0;
      overflow <= w_drop ? 1'b1 : (ovf_clr ? 1'b0 : overflow);
      if (w_event && (!valid || w_hs)) begin
        valid     <= 1'b1;
        buttonNum <= w_idx;
        multi     <= w_multi;
      end else if (w_hs) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_button_encoder.sv
// tb_button_encoder: directed scenarios plus randomized press/glitch segments against a segment-level model
module tb_button_encoder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] buttons = '0;
  logic        ready = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [3:0]  buttonNum;
  logic        valid, multi, overflow, held;
  int n_chk = 0;
  int n_fail = 0;
  bit auto_consume = 1'b0;
  int exp_num [$];
  int exp_multi [$];
  button_encoder #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .buttons(buttons), .ready(ready), .ovf_clr(ovf_clr),
    .buttonNum(buttonNum), .valid(valid), .multi(multi), .overflow(overflow), .held(held)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 0;
  endfunction
  task automatic tick();
    @(negedge clk);
    if (auto_consume) begin
      if (ready) ready = 1'b0;
      else if (valid) begin
        if (exp_num.size() == 0) chk("extra_event", 1, 0);
        else begin
          chk("rnd_num", int'(buttonNum), exp_num.pop_front());
          chk("rnd_multi", int'(multi), exp_multi.pop_front());
        end
        ready = 1'b1;
      end
    end
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    do begin tick(); n++; end while (!valid && n < 30);
  endtask
  task automatic handshake();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask
  task automatic chk_quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin tick(); if (valid) seen++; end
    chk(tag, seen, 0);
  endtask
  initial begin
    int n, seen;
    logic [15:0] model_stable, v, g;
    ticks(2);
    chk("rst_valid", int'(valid), 0);
    chk("rst_num", int'(buttonNum), 0);
    chk("rst_held", int'(held), 0);
    chk("rst_ovf", int'(overflow), 0);
    reset_n = 1'b1;
    ticks(2);
    // single press, latency and handshake
    buttons = 16'h0020;
    wait_valid(n);
    chk("lat_single", int'(n >= 6 && n <= 8), 1);
    chk("single_num", int'(buttonNum), 5);
    chk("single_multi", int'(multi), 0);
    ticks(4);
    chk("single_hold_valid", int'(valid), 1);
    chk("single_held", int'(held), 1);
    handshake();
    chk("single_clear", int'(valid), 0);
    buttons = '0;
    ticks(12);
    chk("release_held", int'(held), 0);
    // short glitch must be filtered
    buttons = 16'h0100;
    ticks(3);
    buttons = '0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (valid || held) seen++; end
    chk("glitch", seen, 0);
    // simultaneous press, extra button while held
    buttons = 16'h8004;
    wait_valid(n);
    chk("multi_seen", int'(valid), 1);
    chk("multi_num", int'(buttonNum), 2);
    chk("multi_flag", int'(multi), 1);
    handshake();
    buttons = 16'h8005;
    chk_quiet("no_repeat", 20);
    buttons = '0;
    ticks(12);
    // dropped event sets overflow
    buttons = 16'h0008;
    ticks(15);
    buttons = '0;
    ticks(15);
    buttons = 16'h0010;
    ticks(15);
    chk("drop_valid", int'(valid), 1);
    chk("drop_num", int'(buttonNum), 3);
    chk("drop_ovf", int'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", int'(overflow), 0);
    chk("ovf_clr_num", int'(buttonNum), 3);
    handshake();
    chk("drop_cleared", int'(valid), 0);
    buttons = '0;
    ticks(12);
    // event coinciding with handshake is accepted
    buttons = 16'h0040;
    wait_valid(n);
    buttons = '0;
    ticks(12);
    buttons = 16'h0200;
    ticks(7);
    ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk);
      if (dut.w_event) seen = 1;
    end
    @(negedge clk);
    ready = 1'b0;
    chk("coincide_valid", int'(valid), 1);
    chk("coincide_num", int'(buttonNum), 9);
    chk("coincide_ovf", int'(overflow), 0);
    handshake();
    buttons = '0;
    ticks(12);
    // reset mid-debounce
    buttons = 16'h0002;
    ticks(4);
    reset_n = 1'b0;
    tick();
    chk("rstmid_all", int'({valid, multi, overflow, held, buttonNum}), 0);
    ticks(3);
    reset_n = 1'b1;
    wait_valid(n);
    chk("rstmid_lat", int'(n >= 6 && n <= 8), 1);
    chk("rstmid_num", int'(buttonNum), 1);
    handshake();
    chk_quiet("rstmid_once", 20);
    buttons = '0;
    ticks(12);
    // randomized segments
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_stable = '0;
    auto_consume = 1'b1;
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 1)) begin
        g = 16'($urandom);
        buttons = g;
        ticks($urandom_range(1, 3));
      end
      case ($urandom_range(0, 2))
        0: v = '0;
        1: v = 16'(1) << $urandom_range(0, 15);
        default: v = 16'($urandom);
      endcase
      if (v != '0 && model_stable == '0) begin
        exp_num.push_back(lowest(v));
        exp_multi.push_back(int'($countones(v) > 1));
      end
      model_stable = v;
      buttons = v;
      ticks($urandom_range(12, 20));
      chk("rnd_held", int'(held), int'(v != '0));
      chk("rnd_pending", exp_num.size(), 0);
      chk("rnd_ovf", int'(overflow), 0);
      exp_num.delete();
      exp_multi.delete();
    end
    auto_consume = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
